// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: shift modes and FSM states.
package shifter_pkg;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions by mode and fill bit.
// SEQ_SHIFTER_ROTATE_EN enables rotate-right for mode 11; otherwise 11 acts as SRL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_work,
  input  logic [SHAMT_W:0]   i_k,
  input  logic [1:0]         i_mode,
  input  logic               i_fill,
  output logic [WIDTH-1:0]   o_work
);

  localparam int unsigned KW = SHAMT_W + 1;

  logic [KW-1:0]    w_kc;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_fill_mask;

  // w_kc = WIDTH-k: position where fill (or wrapped) bits start from the top
  assign w_kc        = KW'(WIDTH) - i_k;
  assign w_srl       = i_work >> i_k;
  assign w_fill_mask = {WIDTH{i_fill}} << w_kc;

  always_comb begin
    o_work = w_srl;
    case (i_mode)
      SH_SLL:  o_work = i_work << i_k;
      SH_SRL:  o_work = w_srl;
      SH_SRA:  o_work = w_srl | w_fill_mask;
      SH_ROTR: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        o_work = w_srl | (i_work << w_kc);
`else
        o_work = w_srl;
`endif
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with valid/ready handshakes, STEP positions per cycle.
// SEQ_SHIFTER_ROTATE_EN (in shift_step) selects ROTR for mode 11.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  localparam int unsigned KW = SHAMT_W + 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_step;
  logic [SHAMT_W-1:0] r_rem;
  logic [1:0]         r_mode;
  logic               r_fill;
  logic [KW-1:0]      w_k;
  logic               w_last;

  // k = min(STEP, rem); the final step is partial when rem < STEP
  assign w_k    = ({1'b0, r_rem} >= KW'(STEP)) ? KW'(STEP) : {1'b0, r_rem};
  assign w_last = (w_k == {1'b0, r_rem});

  shift_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .i_work (r_work),
    .i_k    (w_k),
    .i_mode (r_mode),
    .i_fill (r_fill),
    .o_work (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_work    <= '0;
      r_rem     <= '0;
      r_mode    <= SH_SLL;
      r_fill    <= 1'b0;
      data_out  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      in_ready  <= (w_state_nxt == ST_IDLE);
      out_valid <= (w_state_nxt == ST_DONE);
      busy      <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work <= data_in;
            r_mode <= mode;
            r_rem  <= shamt;
            r_fill <= data_in[WIDTH-1];
            if (shamt == '0) data_out <= data_in;
          end
        end
        ST_SHIFT: begin
          r_work <= w_step;
          r_rem  <= r_rem - w_k[SHAMT_W-1:0];
          if (w_last) data_out <= w_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: STEP=1 and STEP=4 instances share stimulus and are checked against a latency/result model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  mode = '0;
  logic [1:0]  in_ready_d;
  logic [1:0]  out_valid_d;
  logic [1:0]  busy_d;
  logic [31:0] dout_d [2];

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[0]),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid_d[0]),
    .out_ready(out_ready), .data_out(dout_d[0]), .busy(busy_d[0])
  );

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[1]),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid_d[1]),
    .out_ready(out_ready), .data_out(dout_d[1]), .busy(busy_d[1])
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Whole-shift reference from the mode definitions
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
    logic [63:0] dd;
    dd = {d, d} >> s;
    case (m)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return 32'($signed(d) >>> s);
      default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        return dd[31:0];
`else
        return d >> s;
`endif
      end
    endcase
  endfunction

  // Model: phase 0 idle, 1 shifting (cycles left in m_cnt), 2 result held
  int          m_phase [2] = '{0, 0};
  int          m_cnt   [2] = '{0, 0};
  logic [31:0] m_res   [2] = '{32'h0, 32'h0};
  logic [31:0] m_dout  [2] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int stp;
      stp = (i == 0) ? 1 : 4;
      if (!rst_n) begin
        m_phase[i] = 0;
        m_dout[i]  = '0;
      end else begin
        case (m_phase[i])
          0: if (in_valid) begin
            m_res[i] = ref_shift(data_in, int'(shamt), mode);
            m_cnt[i] = (int'(shamt) + stp - 1) / stp;
            if (m_cnt[i] == 0) begin
              m_phase[i] = 2;
              m_dout[i]  = m_res[i];
            end else m_phase[i] = 1;
          end
          1: begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin
              m_phase[i] = 2;
              m_dout[i]  = m_res[i];
            end
          end
          default: if (out_ready) m_phase[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mon_in_ready[%0d]", i), 32'(in_ready_d[i]), 32'(m_phase[i] == 0));
        chk($sformatf("mon_out_valid[%0d]", i), 32'(out_valid_d[i]), 32'(m_phase[i] == 2));
        chk($sformatf("mon_busy[%0d]", i), 32'(busy_d[i]), 32'(m_phase[i] != 0));
        chk($sformatf("mon_data_out[%0d]", i), dout_d[i], m_dout[i]);
      end
    end
  end

  task automatic xact(input string nm, input logic [31:0] d, input int s, input logic [1:0] m,
                      input logic [31:0] exp, input int lat1, input int lat4, input int hold);
    int lat [2];
    int cyc;
    @(posedge clk); #1;
    in_valid = 1'b1; data_in = d; shamt = 5'(s); mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    chk({nm, "_busy1"}, 32'(busy_d[0]), 32'h1);
    chk({nm, "_in_ready4"}, 32'(in_ready_d[1]), 32'h0);
    lat = '{0, 0};
    cyc = 1;
    while (1) begin
      for (int i = 0; i < 2; i++) if (lat[i] == 0 && out_valid_d[i]) lat[i] = cyc;
      if ((lat[0] != 0 && lat[1] != 0) || cyc >= 100) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_lat_step1"}, 32'(lat[0]), 32'(lat1));
    chk({nm, "_lat_step4"}, 32'(lat[1]), 32'(lat4));
    chk({nm, "_data_step1"}, dout_d[0], exp);
    chk({nm, "_data_step4"}, dout_d[1], exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0); data_in = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    end
    if (hold > 0) chk({nm, "_held_data"}, dout_d[0], exp);
    // Consume with in_valid high: must not be accepted in the same cycle
    out_ready = 1'b1; in_valid = 1'b1; data_in = $urandom;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({nm, "_idle_after_consume1"}, 32'(in_ready_d[0]), 32'h1);
    chk({nm, "_idle_after_consume4"}, 32'(in_ready_d[1]), 32'h1);
  endtask

  initial begin
    bit seen;
    logic [31:0] rd;
    int rs;
    logic [1:0] rm;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("reset_in_ready", 32'(in_ready_d), 32'h3);
    chk("reset_out_valid", 32'(out_valid_d), 32'h0);
    chk("reset_busy", 32'(busy_d), 32'h0);
    chk("reset_data_out", dout_d[0] | dout_d[1], 32'h0);
    chk("model_sra_pin", ref_shift(32'h8000_0000, 4, 2'd2), 32'hF800_0000);
    chk("model_sll_pin", ref_shift(32'h0000_0001, 7, 2'd0), 32'h0000_0080);

    xact("sll_4_2",     32'h0000_0004, 2,  2'd0, 32'h0000_0010, 3,  2, 0);
    xact("sra_neg_4",   32'h8000_0000, 4,  2'd2, 32'hF800_0000, 5,  2, 1);
    xact("srl_4",       32'h8000_0000, 4,  2'd1, 32'h0800_0000, 5,  2, 0);
    xact("srl_31",      32'h8000_0000, 31, 2'd1, 32'h0000_0001, 32, 9, 0);
    xact("sll_1_7",     32'h0000_0001, 7,  2'd0, 32'h0000_0080, 8,  3, 2);
    xact("shamt0",      32'hDEAD_BEEF, 0,  2'd0, 32'hDEAD_BEEF, 1,  1, 0);
    xact("sra_neg_31",  32'h8000_0001, 31, 2'd2, 32'hFFFF_FFFF, 32, 9, 5);
    xact("sll_31",      32'h8000_0001, 31, 2'd0, 32'h8000_0000, 32, 9, 0);
    xact("sra_pos_5",   32'h7000_0000, 5,  2'd2, 32'h0380_0000, 6,  3, 0);
`ifdef SEQ_SHIFTER_ROTATE_EN
    xact("mode11_4",    32'h0000_00F1, 4,  2'd3, 32'h1000_000F, 5,  2, 0);
`else
    xact("mode11_4",    32'h0000_00F1, 4,  2'd3, 32'h0000_000F, 5,  2, 0);
`endif

    for (int n = 0; n < 16; n++) begin
      rd = $urandom;
      rs = int'($urandom_range(0, 31));
      rm = 2'($urandom_range(0, 3));
      xact($sformatf("rand%0d", n), rd, rs, rm, ref_shift(rd, rs, rm),
           1 + rs, 1 + (rs + 3) / 4, int'($urandom_range(0, 2)));
    end

    // Reset mid-SHIFT: the in-flight result must never appear
    @(posedge clk); #1;
    in_valid = 1'b1; data_in = 32'h1234_5678; shamt = 5'd20; mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset_in_ready", 32'(in_ready_d), 32'h3);
    chk("midreset_busy", 32'(busy_d), 32'h0);
    chk("midreset_data_out1", dout_d[0], 32'h0);
    chk("midreset_data_out4", dout_d[1], 32'h0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid_d != 2'b00) seen = 1'b1;
    end
    chk("midreset_no_emit", 32'(seen), 32'h0);

    xact("post_reset_sll", 32'h0000_0003, 3, 2'd0, 32'h0000_0018, 4, 2, 0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
